// File: rtl/data_mem_controller_if.sv
// Bundle of consumer-side (LSU) and memory-side request/response signals for the
// data-memory controller; slave is the controller, master is the surrounding system.
interface data_mem_controller_if #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned NUM_CHANNELS  = 1
);
    logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

    logic [NUM_CHANNELS-1:0]                 mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]                 mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_ready;

    modport slave (
        input  consumer_read_valid, consumer_read_address,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        output consumer_read_ready, consumer_read_data, consumer_write_ready,
        output mem_read_valid, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready
    );

    modport master (
        output consumer_read_valid, consumer_read_address,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        input  consumer_read_ready, consumer_read_data, consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready
    );
endinterface

// File: rtl/data_mem_controller.sv
// Round-robin arbiter relaying LSU read/write requests onto external memory channels;
// each channel is a small FSM carrying one transaction at a time.
module data_mem_controller #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned NUM_CHANNELS  = 1,
    parameter bit          WRITE_ENABLE  = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    data_mem_controller_if.slave bus
);
    localparam int unsigned IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StReadWait,
        StWriteWait,
        StReadRelay,
        StWriteRelay
    } state_e;

    state_e               state_q [NUM_CHANNELS];
    state_e               state_d [NUM_CHANNELS];
    logic [IDX_BITS-1:0]  owner_q [NUM_CHANNELS];
    logic [IDX_BITS-1:0]  owner_d [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] addr_q  [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] addr_d  [NUM_CHANNELS];
    logic [DATA_BITS-1:0] wdata_q [NUM_CHANNELS];
    logic [DATA_BITS-1:0] wdata_d [NUM_CHANNELS];
    logic [DATA_BITS-1:0] rdata_q [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] rdata_d [NUM_CONSUMERS];
    logic [IDX_BITS-1:0]  rr_q, rr_d;

    logic [NUM_CONSUMERS-1:0] claimed;
    logic [NUM_CONSUMERS-1:0] taken;
    logic [NUM_CONSUMERS-1:0] write_req;
    logic                     found;
    logic [IDX_BITS-1:0]      sel;
    int                       idx;

    assign write_req = WRITE_ENABLE ? bus.consumer_write_valid : '0;

    // A consumer stays claimed from grant until its channel returns to idle.
    always_comb begin
        claimed = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (state_q[c] != StIdle) claimed[owner_q[c]] = 1'b1;
        end
    end

    always_comb begin
        taken = claimed;
        rr_d  = rr_q;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_d[c] = state_q[c];
            owner_d[c] = owner_q[c];
            addr_d[c]  = addr_q[c];
            wdata_d[c] = wdata_q[c];
        end
        for (int i = 0; i < NUM_CONSUMERS; i++) rdata_d[i] = rdata_q[i];

        // Channels resolve in ascending order; taken accumulates same-cycle claims.
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            unique case (state_q[c])
                StIdle: begin
                    found = 1'b0;
                    for (int k = 0; k < NUM_CONSUMERS; k++) begin
                        idx = int'(rr_q) + k;
                        if (idx >= int'(NUM_CONSUMERS)) idx = idx - int'(NUM_CONSUMERS);
                        sel = IDX_BITS'(idx);
                        if (!found && !taken[sel] &&
                            (bus.consumer_read_valid[sel] || write_req[sel])) begin
                            found      = 1'b1;
                            taken[sel] = 1'b1;
                            owner_d[c] = sel;
                            rr_d       = (int'(sel) == int'(NUM_CONSUMERS) - 1) ? '0
                                                                                : sel + 1'b1;
                            if (bus.consumer_read_valid[sel]) begin
                                state_d[c] = StReadWait;
                                addr_d[c]  = bus.consumer_read_address[sel];
                            end else begin
                                state_d[c] = StWriteWait;
                                addr_d[c]  = bus.consumer_write_address[sel];
                                wdata_d[c] = bus.consumer_write_data[sel];
                            end
                        end
                    end
                end
                StReadWait: begin
                    if (bus.mem_read_ready[c]) begin
                        state_d[c]          = StReadRelay;
                        rdata_d[owner_q[c]] = bus.mem_read_data[c];
                    end
                end
                StWriteWait: begin
                    if (bus.mem_write_ready[c]) state_d[c] = StWriteRelay;
                end
                StReadRelay: begin
                    if (!bus.consumer_read_valid[owner_q[c]]) state_d[c] = StIdle;
                end
                StWriteRelay: begin
                    if (!bus.consumer_write_valid[owner_q[c]]) state_d[c] = StIdle;
                end
                default: state_d[c] = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= StIdle;
                owner_q[c] <= '0;
                addr_q[c]  <= '0;
                wdata_q[c] <= '0;
            end
            for (int i = 0; i < NUM_CONSUMERS; i++) rdata_q[i] <= '0;
        end else begin
            rr_q <= rr_d;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                owner_q[c] <= owner_d[c];
                addr_q[c]  <= addr_d[c];
                wdata_q[c] <= wdata_d[c];
            end
            for (int i = 0; i < NUM_CONSUMERS; i++) rdata_q[i] <= rdata_d[i];
        end
    end

    always_comb begin
        bus.consumer_read_ready  = '0;
        bus.consumer_write_ready = '0;
        bus.mem_read_valid       = '0;
        bus.mem_read_address     = '0;
        bus.mem_write_valid      = '0;
        bus.mem_write_address    = '0;
        bus.mem_write_data       = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (state_q[c] == StReadRelay) bus.consumer_read_ready[owner_q[c]] = 1'b1;
            if (state_q[c] == StWriteRelay) bus.consumer_write_ready[owner_q[c]] = 1'b1;
            bus.mem_read_valid[c]   = (state_q[c] == StReadWait);
            bus.mem_read_address[c] = addr_q[c];
            if (WRITE_ENABLE) begin
                bus.mem_write_valid[c]   = (state_q[c] == StWriteWait);
                bus.mem_write_address[c] = addr_q[c];
                bus.mem_write_data[c]    = wdata_q[c];
            end
        end
        for (int i = 0; i < NUM_CONSUMERS; i++) bus.consumer_read_data[i] = rdata_q[i];
    end
endmodule
